// File: rtl/dsp_shared_server_if.sv
// Flat request/result bus between the synth's calculator clients and the shared DSP server.
// Client k owns request bits [92k+91:92k] and result bits [48k+47:48k].
interface dsp_shared_server_if #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned COLL_CNT_W  = 8
);
  logic [92*NUM_CLIENTS-1:0] dsp_ins_flat_all;
  logic [48*NUM_CLIENTS-1:0] dsp_outs_flat_all;
  logic                      busy;
  logic                      collision;
  logic [COLL_CNT_W-1:0]     collision_cnt;

  modport master (
    output dsp_ins_flat_all,
    input  dsp_outs_flat_all, busy, collision, collision_cnt
  );

  modport slave (
    input  dsp_ins_flat_all,
    output dsp_outs_flat_all, busy, collision, collision_cnt
  );
endinterface

// File: rtl/dsp_shared_server.sv
// Shared 2-stage multiply/add server (DSP48A1 opmode subset) for up to 8 clients.
// Fixed-priority arbitration, losers dropped; per-client result hold registers.
module dsp_shared_server #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned COLL_CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  dsp_shared_server_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef struct packed {
    logic [7:0]  opmode;
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] c;
  } dsp_req_t;

  logic [NUM_CLIENTS-1:0] req_c;
  dsp_req_t               cur_c;
  dsp_req_t               win_c;
  logic                   win_valid_c;
  logic [IDX_W-1:0]       win_idx_c;
  logic                   multi_c;

  logic                   s1_valid_q;
  logic [IDX_W-1:0]       s1_owner_q;
  logic                   s1_sub_q;
  logic [1:0]             s1_xsel_q;
  logic [1:0]             s1_zsel_q;
  logic [17:0]            s1_a_q;
  logic [17:0]            s1_b_q;
  logic [47:0]            s1_c_q;

  logic [47:0]            hold_q [NUM_CLIENTS];
  logic                   busy_q;
  logic                   collision_q;
  logic [COLL_CNT_W-1:0]  coll_cnt_q;

  logic signed [35:0]     prod_c;
  logic [47:0]            hold_sel_c;
  logic [47:0]            x_c;
  logic [47:0]            z_c;
  logic [47:0]            result_d;

  // Scan from the top so the lowest requesting index wins.
  always_comb begin
    req_c       = '0;
    cur_c       = '0;
    win_c       = '0;
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
      cur_c    = bus.dsp_ins_flat_all[92*k +: 92];
      req_c[k] = |cur_c.opmode;
      if (req_c[k]) begin
        win_c       = cur_c;
        win_valid_c = 1'b1;
        win_idx_c   = IDX_W'(k);
      end
    end
    multi_c = ($countones(req_c) > 1);
  end

  // Stage-2 operand selection; hold feedback sees the write from the previous cycle.
  always_comb begin
    prod_c     = $signed(s1_a_q) * $signed(s1_b_q);
    hold_sel_c = hold_q[s1_owner_q];
    unique case (s1_xsel_q)
      2'b01:   x_c = {{12{prod_c[35]}}, prod_c};
      2'b10:   x_c = hold_sel_c;
      default: x_c = '0;
    endcase
    unique case (s1_zsel_q)
      2'b10:   z_c = hold_sel_c;
      2'b11:   z_c = s1_c_q;
      default: z_c = '0;
    endcase
    result_d = s1_sub_q ? (z_c - x_c) : (z_c + x_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= '0;
      s1_sub_q    <= 1'b0;
      s1_xsel_q   <= '0;
      s1_zsel_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
      for (int k = 0; k < int'(NUM_CLIENTS); k++) hold_q[k] <= '0;
    end else begin
      s1_valid_q  <= win_valid_c;
      busy_q      <= win_valid_c | s1_valid_q;
      collision_q <= multi_c;
      if (multi_c && (coll_cnt_q != '1)) coll_cnt_q <= coll_cnt_q + COLL_CNT_W'(1);
      if (win_valid_c) begin
        s1_owner_q <= win_idx_c;
        s1_sub_q   <= win_c.opmode[7];
        s1_xsel_q  <= win_c.opmode[1:0];
        s1_zsel_q  <= win_c.opmode[3:2];
        s1_a_q     <= win_c.a;
        s1_b_q     <= win_c.b;
        s1_c_q     <= win_c.c;
      end
      if (s1_valid_q) hold_q[s1_owner_q] <= result_d;
    end
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_out
    assign bus.dsp_outs_flat_all[48*g +: 48] = hold_q[g];
  end

  assign bus.busy          = busy_q;
  assign bus.collision     = collision_q;
  assign bus.collision_cnt = coll_cnt_q;
endmodule

// File: tb/tb_dsp_shared_server.sv
// Directed bench for dsp_shared_server with two clients: latency, opmode decode,
// collisions and saturation, accumulate feedback, alternating clients, mid-flight reset.
module tb_dsp_shared_server;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  dsp_shared_server_if #(.NUM_CLIENTS(2), .COLL_CNT_W(8)) bus ();

  dsp_shared_server #(.NUM_CLIENTS(2), .COLL_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [47:0] slot0;
  logic [47:0] slot1;
  assign slot0 = bus.dsp_outs_flat_all[47:0];
  assign slot1 = bus.dsp_outs_flat_all[95:48];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [7:0] op, input logic [17:0] a,
                         input logic [17:0] b, input logic [47:0] c);
    bus.dsp_ins_flat_all[92*k +: 92] = {op, a, b, c};
  endtask

  task automatic clr_req();
    bus.dsp_ins_flat_all = '0;
  endtask

  logic [47:0] exp0, exp1, pval, nval;
  logic        pvalid;
  int          pwho;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    bus.dsp_ins_flat_all = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slot0", slot0, 48'h0);
    chk("rst_slot1", slot1, 48'h0);
    chk("rst_busy", 48'(bus.busy), 48'h0);
    chk("rst_coll", 48'(bus.collision), 48'h0);
    chk("rst_cnt", 48'(bus.collision_cnt), 48'h0);
    reset = 1'b0;
    tick();

    // Client 0 MULT: 2^16 * 2^15
    set_req(0, 8'h01, 18'h10000, 18'h08000, 48'h0);
    tick();
    clr_req();
    chk("mult_busy_t1", 48'(bus.busy), 48'h1);
    chk("mult_slot0_t1", slot0, 48'h0);
    tick();
    chk("mult_slot0_t2", slot0, 48'h0000_8000_0000);
    chk("mult_slot1_t2", slot1, 48'h0);
    chk("mult_busy_t2", 48'(bus.busy), 48'h1);
    tick();
    chk("mult_busy_t3", 48'(bus.busy), 48'h0);

    // Client 1 C - A*B: 0x3000_0000 - 2^32
    set_req(1, 8'h8D, 18'h10000, 18'h10000, 48'h0000_3000_0000);
    tick();
    clr_req();
    tick();
    chk("cmult_slot1", slot1, 48'hFFFF_3000_0000);
    chk("cmult_slot0", slot0, 48'h0000_8000_0000);

    // Single collision: client 0 wins, client 1 dropped
    set_req(0, 8'h01, 18'h00005, 18'h00007, 48'h0);
    set_req(1, 8'h0C, 18'h0, 18'h0, 48'h0000_0000_03E7);
    tick();
    clr_req();
    chk("coll_pulse", 48'(bus.collision), 48'h1);
    chk("coll_cnt1", 48'(bus.collision_cnt), 48'h1);
    tick();
    chk("coll_pulse_end", 48'(bus.collision), 48'h0);
    chk("coll_slot0", slot0, 48'd35);
    chk("coll_slot1", slot1, 48'hFFFF_3000_0000);

    // 300 more collision cycles (op 0x10: X=0, Z=0) saturate the counter
    set_req(0, 8'h10, 18'h0, 18'h0, 48'h0);
    set_req(1, 8'h10, 18'h0, 18'h0, 48'h0);
    repeat (300) tick();
    clr_req();
    chk("coll_sat", 48'(bus.collision_cnt), 48'hFF);
    tick();
    tick();
    chk("coll_sat_hold", 48'(bus.collision_cnt), 48'hFF);
    chk("sat_slot0_zero", slot0, 48'h0);
    chk("sat_slot1_kept", slot1, 48'hFFFF_3000_0000);

    // Back-to-back accumulate hold + 2*3
    set_req(0, 8'h09, 18'h00002, 18'h00003, 48'h0);
    tick();
    tick();
    chk("acc_6", slot0, 48'd6);
    tick();
    clr_req();
    chk("acc_12", slot0, 48'd12);
    tick();
    chk("acc_18", slot0, 48'd18);
    tick();
    chk("acc_hold", slot0, 48'd18);

    // Alternating clients, each slot updates 2 cycles after its own issue
    exp0   = 48'd18;
    exp1   = 48'hFFFF_3000_0000;
    pvalid = 1'b0;
    pwho   = 0;
    pval   = '0;
    for (int i = 0; i < 8; i++) begin
      clr_req();
      if (i % 2 == 0) begin
        set_req(0, 8'h01, 18'(i + 1), 18'd3, 48'h0);
        nval = 48'(3 * (i + 1));
      end else begin
        set_req(1, 8'h0C, 18'h0, 18'h0, 48'(100 + i));
        nval = 48'(100 + i);
      end
      tick();
      if (pvalid) begin
        if (pwho == 0) exp0 = pval;
        else           exp1 = pval;
      end
      pvalid = 1'b1;
      pwho   = i % 2;
      pval   = nval;
      chk($sformatf("alt%0d_slot0", i), slot0, exp0);
      chk($sformatf("alt%0d_slot1", i), slot1, exp1);
    end
    clr_req();
    tick();
    if (pwho == 0) exp0 = pval;
    else           exp1 = pval;
    chk("alt_final_slot0", slot0, exp0);
    chk("alt_final_slot1", slot1, exp1);
    chk("alt_final_exp0", slot0, 48'd21);
    chk("alt_final_exp1", slot1, 48'd107);

    // Reset during stage 1 discards the in-flight op
    set_req(1, 8'h0C, 18'h0, 18'h0, 48'h0000_0000_1234);
    tick();
    clr_req();
    #2 reset = 1'b1;
    #1;
    chk("mrst_slot0", slot0, 48'h0);
    chk("mrst_slot1", slot1, 48'h0);
    chk("mrst_busy", 48'(bus.busy), 48'h0);
    chk("mrst_cnt", 48'(bus.collision_cnt), 48'h0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("post_rst_slot1", slot1, 48'h0);
    chk("post_rst_slot0", slot0, 48'h0);
    chk("post_rst_busy", 48'(bus.busy), 48'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
